// File: rtl/flash_read_responder.sv
// Single-outstanding Avalon-MM read responder between the sample-fetch FSM and the flash controller.
// Optional read timeout/abort enabled by defining FLASH_READ_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// ISSUE     | flash_mem_read held with a stable address until waitrequest drops
// WAIT_DATA | read accepted by controller, waiting for readdatavalid
// RESPOND   | one-cycle resp_valid pulse, then back to IDLE
module flash_read_responder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [22:0] req_address,
  output logic        req_ready,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        resp_error,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESPOND} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [22:0] r_addr;
  logic [31:0] r_data;
  logic        r_error;
  logic        w_accept;
  logic        w_capture;
  logic        w_busy;
  logic        w_timeout;

  assign w_accept = (r_state == IDLE) && req;
  assign w_busy   = (r_state == ISSUE) || (r_state == WAIT_DATA);

`ifdef FLASH_READ_TIMEOUT_EN
  // Down-counter loaded on accept; terminal count marks the last allowed busy cycle.
  logic [15:0] r_tmr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr <= 16'd0;
    end else if (w_accept) begin
      r_tmr <= TIMEOUT_CYCLES - 16'd1;
    end else if (w_busy && (r_tmr != 16'd0)) begin
      r_tmr <= r_tmr - 16'd1;
    end
  end

  assign w_timeout = w_busy && (r_tmr == 16'd0);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) w_next = ISSUE;
      end
      ISSUE: begin
        // Data may already be valid on the cycle the command is accepted.
        if (!flash_mem_waitrequest && flash_mem_readdatavalid) begin
          w_capture = 1'b1;
          w_next    = RESPOND;
        end else if (w_timeout) begin
          w_next = RESPOND;
        end else if (!flash_mem_waitrequest) begin
          w_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          w_capture = 1'b1;
          w_next    = RESPOND;
        end else if (w_timeout) begin
          w_next = RESPOND;
        end
      end
      RESPOND: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 23'h0;
    end else if (w_accept) begin
      r_addr <= req_address;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= 32'h0;
      r_error <= 1'b0;
    end else if (w_capture) begin
      r_data  <= flash_mem_readdata;
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_data  <= 32'h0;
      r_error <= 1'b1;
    end
  end

  assign req_ready            = (r_state == IDLE);
  assign resp_valid           = (r_state == RESPOND);
  assign resp_data            = r_data;
  assign resp_error           = r_error;
  assign flash_mem_read       = (r_state == ISSUE);
  assign flash_mem_address    = r_addr;
  assign flash_mem_byteenable = 4'hF;

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed self-checking bench for flash_read_responder.
// Timeout expectations follow whether FLASH_READ_TIMEOUT_EN is defined for the build.
module tb_flash_read_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic [22:0] req_address;
  logic        req_ready;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_error;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  flash_read_responder #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req                     (req),
    .req_address             (req_address),
    .req_ready               (req_ready),
    .resp_data               (resp_data),
    .resp_valid              (resp_valid),
    .resp_error              (resp_error),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a read, hold waitrequest for 'stalls' ISSUE cycles, then return data after 'dly' WAIT_DATA cycles.
  task automatic do_read(input string tag, input logic [22:0] a, input int stalls,
                         input int dly, input logic [31:0] d);
    req         = 1'b1;
    req_address = a;
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    step();
    req         = 1'b0;
    req_address = 23'h0;
    for (int i = 0; i <= stalls; i++) begin
      flash_mem_waitrequest = (i < stalls);
      chk({tag, ".read"}, {31'b0, flash_mem_read}, 32'd1);
      chk({tag, ".addr"}, {9'b0, flash_mem_address}, {9'b0, a});
      step();
    end
    flash_mem_waitrequest = 1'b0;
    for (int j = 0; j < dly; j++) begin
      chk({tag, ".wait_valid"}, {31'b0, resp_valid}, 32'd0);
      step();
    end
    chk({tag, ".read_low"}, {31'b0, flash_mem_read}, 32'd0);
    chk({tag, ".early_valid"}, {31'b0, resp_valid}, 32'd0);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = d;
    step();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = 32'h1357_9BDF;
    chk({tag, ".valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".data"}, resp_data, d);
    chk({tag, ".err"}, {31'b0, resp_error}, 32'd0);
    step();
    chk({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;

    reset                   = 1'b1;
    req                     = 1'b0;
    req_address             = 23'h0;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdata      = 32'h0;
    flash_mem_readdatavalid = 1'b0;
    step();
    step();
    chk("rst.read", {31'b0, flash_mem_read}, 32'd0);
    chk("rst.addr", {9'b0, flash_mem_address}, 32'd0);
    chk("rst.data", resp_data, 32'd0);
    chk("rst.valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.err", {31'b0, resp_error}, 32'd0);
    chk("rst.be", {28'b0, flash_mem_byteenable}, 32'hF);
    reset = 1'b0;
    step();
    chk("rst.ready", {31'b0, req_ready}, 32'd1);

    // Zero-stall read: resp_valid at accept+3.
    do_read("zs", 23'h000010, 0, 0, 32'hA5B6C7D8);
    // Four waitrequest stalls: read held 5 cycles, resp_valid at accept+7.
    do_read("stall", 23'h7FFFFF, 4, 0, 32'h0BAD_F00D);
    // Extra readdatavalid delay.
    do_read("dly", 23'h2AAAAA, 1, 2, 32'h5555_AAAA);

    // Data valid in the same ISSUE cycle waitrequest drops: resp_valid at accept+2.
    req         = 1'b1;
    req_address = 23'h000123;
    step();
    req                     = 1'b0;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'hCAFE_0001;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("fast.valid", {31'b0, resp_valid}, 32'd1);
    chk("fast.data", resp_data, 32'hCAFE_0001);
    step();

    // Back-to-back with req held high: second accept waits for first response.
    req         = 1'b1;
    req_address = 23'h000001;
    step();
    req_address = 23'h000002;
    chk("b2b.busy1", {31'b0, req_ready}, 32'd0);
    step();
    chk("b2b.addr_hold", {9'b0, flash_mem_address}, 32'd1);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'h1111_1111;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("b2b.valid1", {31'b0, resp_valid}, 32'd1);
    chk("b2b.data1", resp_data, 32'h1111_1111);
    chk("b2b.busy2", {31'b0, req_ready}, 32'd0);
    step();
    chk("b2b.accept2", {31'b0, req_ready}, 32'd1);
    step();
    req = 1'b0;
    chk("b2b.addr2", {9'b0, flash_mem_address}, 32'd2);
    chk("b2b.read2", {31'b0, flash_mem_read}, 32'd1);
    step();
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'h2222_2222;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("b2b.valid2", {31'b0, resp_valid}, 32'd1);
    chk("b2b.data2", resp_data, 32'h2222_2222);
    step();

    // Stray readdatavalid in IDLE is ignored.
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'h0000_1234;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("stray.data", resp_data, 32'h2222_2222);
    chk("stray.valid", {31'b0, resp_valid}, 32'd0);
    chk("stray.ready", {31'b0, req_ready}, 32'd1);

    // Reset in WAIT_DATA, then late readdatavalid is discarded.
    req         = 1'b1;
    req_address = 23'h000005;
    step();
    req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset                   = 1'b0;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = 32'hDEADBEEF;
    chk("mrst.ready0", {31'b0, req_ready}, 32'd1);
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("mrst.valid", {31'b0, resp_valid}, 32'd0);
    chk("mrst.data", resp_data, 32'd0);
    chk("mrst.ready", {31'b0, req_ready}, 32'd1);
    chk("mrst.addr", {9'b0, flash_mem_address}, 32'd0);

    // Give resp_data a nonzero value so a timeout clear is observable.
    do_read("pre", 23'h000042, 0, 0, 32'h7777_8888);

    // Readdatavalid never arrives.
    req         = 1'b1;
    req_address = 23'h000777;
    step();
    req  = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (resp_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        step();
      end
    end
`ifdef FLASH_READ_TIMEOUT_EN
    chk("to.seen", {31'b0, seen}, 32'd1);
    chk("to.latency", lat, 32'd17);
    chk("to.err", {31'b0, resp_error}, 32'd1);
    chk("to.data", resp_data, 32'd0);
    step();
    chk("to.idle", {31'b0, req_ready}, 32'd1);
`else
    chk("nto.seen", {31'b0, seen}, 32'd0);
    chk("nto.busy", {31'b0, req_ready}, 32'd0);
    chk("nto.err", {31'b0, resp_error}, 32'd0);
    chk("nto.data", resp_data, 32'h7777_8888);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("nto.recover", {31'b0, req_ready}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
